// File: rtl/wb_arbiter.sv
// Writeback scheduler: up to two round-robin grants per cycle onto regfile ports 1/2, plus a busy scoreboard.
// Latency: accepted at t, write registered at edge ending t+1; same-address losers and busy issues wait (ready=0).
module wb_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic [AW-1:0]     qa1,
  input  logic [AW-1:0]     qa2,
  output logic              qbusy1,
  output logic              qbusy2,
  output logic              we1,
  output logic              we2,
  output logic [AW-1:0]     aw1,
  output logic [AW-1:0]     aw2,
  output logic [DW-1:0]     wd1,
  output logic [DW-1:0]     wd2
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   last_idx;
  logic            a_vld, b_vld;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_data, b_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Slot B skips anything aliasing slot A's address so the two ports never collide.
  always_comb begin
    req_ready = '0;
    a_vld     = 1'b0;
    b_vld     = 1'b0;
    a_addr    = '0;
    b_addr    = '0;
    a_data    = '0;
    b_data    = '0;
    last_idx  = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx] && !b_vld) begin
        if (!a_vld) begin
          a_vld          = 1'b1;
          a_addr         = req_addr[idx*AW +: AW];
          a_data         = req_data[idx*DW +: DW];
          req_ready[idx] = 1'b1;
          last_idx       = PW'(idx);
        end else if (req_addr[idx*AW +: AW] != a_addr) begin
          b_vld          = 1'b1;
          b_addr         = req_addr[idx*AW +: AW];
          b_data         = req_data[idx*DW +: DW];
          req_ready[idx] = 1'b1;
          last_idx       = PW'(idx);
        end
      end
    end
    rr_nxt = (int'(last_idx) == NREQ - 1) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      we1    <= 1'b0;
      we2    <= 1'b0;
      aw1    <= '0;
      aw2    <= '0;
      wd1    <= '0;
      wd2    <= '0;
    end else begin
      we1 <= a_vld;
      we2 <= b_vld;
      if (a_vld) begin
        aw1    <= a_addr;
        wd1    <= a_data;
        rr_ptr <= rr_nxt;
      end
      if (b_vld) begin
        aw2 <= b_addr;
        wd2 <= b_data;
      end
    end
  end

  assign iss_ready = ~busy[iss_rd];
  assign qbusy1    = busy[qa1];
  assign qbusy2    = busy[qa2];

  // Clears come from the registered write ports; a same-edge issue set overrides them.
  always_comb begin
    busy_nxt = busy;
    if (we1) busy_nxt[aw1] = 1'b0;
    if (we2) busy_nxt[aw2] = 1'b0;
    if (iss_valid && iss_ready) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes are queued per port and checked by a monitor.
module tb_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_ready;
  logic [AW-1:0]     qa1, qa2;
  logic              qbusy1, qbusy2;
  logic              we1, we2;
  logic [AW-1:0]     aw1, aw2;
  logic [DW-1:0]     wd1, wd2;

  int checks = 0;
  int failures = 0;
  wr_t exp1_q[$];
  wr_t exp2_q[$];

  wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .qa1(qa1), .qa2(qa2), .qbusy1(qbusy1), .qbusy2(qbusy2),
    .we1(we1), .we2(we2), .aw1(aw1), .aw2(aw2), .wd1(wd1), .wd2(wd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp1_q.push_back(e);
  endtask

  task automatic push2(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp2_q.push_back(e);
  endtask

  // Monitor: every write-port pulse must match the oldest expected write for that port.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (we1) begin
        if (exp1_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL port1_unexpected: got aw1=%0d wd1=%h expected no write", aw1, wd1);
        end else begin
          e = exp1_q.pop_front();
          chk("port1_aw", 32'(aw1), 32'(e.a));
          chk("port1_wd", wd1, e.d);
        end
      end
      if (we2) begin
        if (exp2_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL port2_unexpected: got aw2=%0d wd2=%h expected no write", aw2, wd2);
        end else begin
          e = exp2_q.pop_front();
          chk("port2_aw", 32'(aw2), 32'(e.a));
          chk("port2_wd", wd2, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; qa1 = '0; qa2 = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_we1", 32'(we1), 0);
    chk("rst_we2", 32'(we2), 0);
    chk("rst_aw1", 32'(aw1), 0);
    chk("rst_wd1", wd1, 0);
    chk("rst_qbusy1", 32'(qbusy1), 0);
    rst = 1'b0;

    // Two grants from pointer 0
    set_req(0, 1'b1, 6'd5, 32'h11);
    set_req(2, 1'b1, 6'd9, 32'h22);
    #1 chk("two_grant_ready", 32'(req_ready), 32'b0101);
    push1(6'd5, 32'h11); push2(6'd9, 32'h22);
    @(negedge clk);
    req_valid = '0;

    // Pointer is 3: lone req3 wins and wraps pointer to 0
    set_req(3, 1'b1, 6'd1, 32'h33);
    #1 chk("ptr3_ready", 32'(req_ready), 32'b1000);
    push1(6'd1, 32'h33);
    @(negedge clk);
    req_valid = '0;

    // Address conflict: req1 and req3 both target r7
    set_req(1, 1'b1, 6'd7, 32'h71);
    set_req(3, 1'b1, 6'd7, 32'h73);
    #1 chk("conflict_ready", 32'(req_ready), 32'b0010);
    push1(6'd7, 32'h71);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1 chk("conflict_retry_ready", 32'(req_ready), 32'b1000);
    push1(6'd7, 32'h73);
    @(negedge clk);
    req_valid = '0;

    // Fairness: all four held valid for four cycles
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(10 + i), 32'h40 + i);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk("fair_ready_even", 32'(req_ready), 32'b0011);
        push1(6'd10, 32'h40); push2(6'd11, 32'h41);
      end else begin
        chk("fair_ready_odd", 32'(req_ready), 32'b1100);
        push1(6'd12, 32'h42); push2(6'd13, 32'h43);
      end
      @(negedge clk);
    end
    req_valid = '0;

    // Scoreboard: issue r12, WAW stall, clear by writeback
    iss_valid = 1'b1; iss_rd = 6'd12; qa1 = 6'd12;
    #1 chk("iss12_ready", 32'(iss_ready), 1);
    chk("iss12_no_forward", 32'(qbusy1), 0);
    @(negedge clk); #1;
    chk("iss12_busy", 32'(qbusy1), 1);
    chk("iss12_waw_stall", 32'(iss_ready), 0);
    iss_valid = 1'b0;
    set_req(0, 1'b1, 6'd12, 32'hC0);
    #1 chk("wb12_ready", 32'(req_ready), 32'b0001);
    push1(6'd12, 32'hC0);
    @(negedge clk);
    req_valid = '0;
    #1 chk("wb12_busy_during_we", 32'(qbusy1), 1);
    chk("wb12_stall_during_we", 32'(iss_ready), 0);
    @(negedge clk); #1;
    chk("wb12_cleared", 32'(qbusy1), 0);
    chk("wb12_iss_ready", 32'(iss_ready), 1);

    // Set/clear collision on r20 (pointer now 1)
    set_req(1, 1'b1, 6'd20, 32'h200);
    #1 chk("coll_ready", 32'(req_ready), 32'b0010);
    push1(6'd20, 32'h200);
    @(negedge clk);
    req_valid = '0;
    iss_valid = 1'b1; iss_rd = 6'd20;
    #1 chk("coll_iss_ready", 32'(iss_ready), 1);
    @(negedge clk);
    iss_valid = 1'b0; qa1 = 6'd20; qa2 = 6'd20;
    #1 chk("coll_set_wins1", 32'(qbusy1), 1);
    chk("coll_set_wins2", 32'(qbusy2), 1);

    // Reset mid-stream with we1 high and r20 busy (pointer now 2)
    set_req(2, 1'b1, 6'd30, 32'h300);
    #1 chk("pre_rst_ready", 32'(req_ready), 32'b0100);
    push1(6'd30, 32'h300);
    @(negedge clk);
    set_req(2, 1'b1, 6'd31, 32'h301);
    rst = 1'b1;
    #1 chk("midrst_we1", 32'(we1), 0);
    chk("midrst_we2", 32'(we2), 0);
    chk("midrst_aw1", 32'(aw1), 0);
    chk("midrst_qbusy1", 32'(qbusy1), 0);
    chk("midrst_ready_follows", 32'(req_ready), 32'b0100);
    @(negedge clk); #1;
    chk("midrst_no_latch", 32'(we1), 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(req_ready), 32'b0100);
    push1(6'd31, 32'h301);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("port1_queue_drained", exp1_q.size(), 0);
    chk("port2_queue_drained", exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
